// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_arbiter_pkg : ALU opcodes, requester indices and shared types          |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
package alu_arbiter_pkg;

    // Opcode values match the shared ALU opcode set
    localparam logic [3:0] ALU_ID  = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_AND = 4'h3;
    localparam logic [3:0] ALU_OR  = 4'h4;
    localparam logic [3:0] ALU_XOR = 4'h5;

    localparam int ALU_ARB_NREQ = 3;
    localparam int ALU_DATA_W   = 16;
    localparam int REQ_EXEC     = 0;
    localparam int REQ_PC       = 1;
    localparam int REQ_BR       = 2;

    localparam logic [0:0] c_SLOT_EMPTY = 1'b0;
    localparam logic [0:0] c_SLOT_FULL  = 1'b1;

    typedef struct packed {
        logic [3:0]            op;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic                  cin;
    } alu_req_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_arbiter_if : request/response bundle between requesters and arbiter   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
interface alu_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [4*N_REQ-1:0]      req_op;
    logic [DATA_W*N_REQ-1:0] req_a;
    logic [DATA_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]        req_cin;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [DATA_W*N_REQ-1:0] rsp_result;
    logic [N_REQ-1:0]        rsp_cout;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_picker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_picker : combinational round-robin picker, search from last_grant+1    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module rr_picker #(
    parameter int N_REQ = 3
) (
    input  wire logic [N_REQ-1:0] i_elig,
    input  wire logic [1:0]       i_last_grant,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [1:0]       o_grant_idx
);
    logic [1:0] w_cand;
    logic       w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_cand      = '0;
        w_found     = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = 2'((int'(i_last_grant) + k) % N_REQ);
            if (!w_found && i_elig[w_cand]) begin
                w_found          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_grant_idx      = w_cand;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_arbiter : round-robin sharing of one ALU with registered responses    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ  = ALU_ARB_NREQ,
    parameter int DATA_W = ALU_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    alu_arbiter_if.slave           bus,
    output logic      [DATA_W-1:0] alu_input1,
    output logic      [DATA_W-1:0] alu_input2,
    output logic                   alu_cin,
    output logic      [3:0]        alu_op,
    input  wire logic [DATA_W-1:0] alu_result,
    input  wire logic              alu_cout,
    output logic      [1:0]        grant_id,
    output logic      [15:0]       conflict_cnt
);
    logic [N_REQ-1:0]        r_state;
    logic [DATA_W*N_REQ-1:0] r_result;
    logic [N_REQ-1:0]        r_cout;
    logic [1:0]              r_last;
    logic [15:0]             r_conf;

    logic [N_REQ-1:0]        w_elig;
    logic [N_REQ-1:0]        w_gnt;
    logic [1:0]              w_gidx;
    logic                    w_any;
    logic                    w_multi;
    alu_req_t                w_win;

    // A full slot may accept a new grant only when its old result leaves this cycle
    assign w_elig  = bus.req_valid & (~r_state | bus.rsp_ready);
    assign w_any   = |w_gnt;
    assign w_multi = ($countones(w_elig) > 1);

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .i_elig       (w_elig),
        .i_last_grant (r_last),
        .o_grant      (w_gnt),
        .o_grant_idx  (w_gidx)
    );

    always_comb begin
        w_win.op  = ALU_ID;
        w_win.a   = '0;
        w_win.b   = '0;
        w_win.cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win.op  = bus.req_op[i*4 +: 4];
                w_win.a   = bus.req_a[i*DATA_W +: DATA_W];
                w_win.b   = bus.req_b[i*DATA_W +: DATA_W];
                w_win.cin = bus.req_cin[i];
            end
        end
    end

    assign alu_op         = w_win.op;
    assign alu_input1     = w_win.a;
    assign alu_input2     = w_win.b;
    assign alu_cin        = w_win.cin;
    assign grant_id       = w_gidx;
    assign conflict_cnt   = r_conf;
    assign bus.req_ready  = w_gnt;
    assign bus.rsp_valid  = r_state;
    assign bus.rsp_result = r_result;
    assign bus.rsp_cout   = r_cout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= {N_REQ{c_SLOT_EMPTY}};
            r_result <= '0;
            r_cout   <= '0;
            r_last   <= 2'(N_REQ - 1);
            r_conf   <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case (r_state[i])
                    c_SLOT_EMPTY: if (w_gnt[i]) r_state[i] <= c_SLOT_FULL;
                    default:      if (!w_gnt[i] && bus.rsp_ready[i]) r_state[i] <= c_SLOT_EMPTY;
                endcase
                if (w_gnt[i]) begin
                    r_result[i*DATA_W +: DATA_W] <= alu_result;
                    r_cout[i]                    <= alu_cout;
                end
            end
            if (w_any) r_last <= w_gidx;
            if (w_multi && r_conf != 16'hFFFF) r_conf <= r_conf + 16'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_alu_arbiter : table vectors plus scoreboard for alu_arbiter            |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [15:0] alu_input1, alu_input2, alu_result;
    logic        alu_cin, alu_cout;
    logic [3:0]  alu_op;
    logic [1:0]  grant_id;
    logic [15:0] conflict_cnt;

    int checks   = 0;
    int failures = 0;

    alu_arbiter_if #(.N_REQ(3), .DATA_W(16)) bus ();

    alu_arbiter #(.N_REQ(3), .DATA_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .alu_input1   (alu_input1),
        .alu_input2   (alu_input2),
        .alu_cin      (alu_cin),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .grant_id     (grant_id),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
        case (op)
            ALU_ADD: return {1'b0, a} + {1'b0, b} + {16'h0, cin};
            ALU_SUB: return {1'b0, a} - {1'b0, b} - {16'h0, cin};
            ALU_AND: return {1'b0, a & b};
            ALU_OR:  return {1'b0, a | b};
            ALU_XOR: return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    assign {alu_cout, alu_result} = alu_f(alu_op, alu_input1, alu_input2, alu_cin);

    // Scoreboard: each slot holds at most one outstanding expected response
    logic [16:0] sbq [3][$];
    int          exp_last = 2;
    logic [15:0] exp_conf = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic cin);
        bus.req_op[i*4 +: 4]   = op;
        bus.req_a[i*16 +: 16]  = a;
        bus.req_b[i*16 +: 16]  = b;
        bus.req_cin[i]         = cin;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) sbq[i].delete();
        exp_last = 2;
        exp_conf = '0;
    endtask

    task automatic monitor();
        logic [2:0]  full, elig, gnt;
        logic [1:0]  gid, c;
        logic [16:0] e;
        for (int i = 0; i < 3; i++) full[i] = (sbq[i].size() != 0);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(full));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(exp_conf));
        elig = bus.req_valid & (~full | bus.rsp_ready);
        gnt = '0;
        gid = '0;
        for (int k = 1; k <= 3; k++) begin
            c = 2'((exp_last + k) % 3);
            if (gnt == 3'b000 && elig[c]) begin
                gnt[c] = 1'b1;
                gid    = c;
            end
        end
        chk("req_ready", 64'(bus.req_ready), 64'(gnt));
        if (gnt != 3'b000) begin
            chk("grant_id", 64'(grant_id), 64'(gid));
            chk("alu_drive", 64'({alu_op, alu_cin, alu_input1, alu_input2}),
                64'({bus.req_op[gid*4 +: 4], bus.req_cin[gid],
                     bus.req_a[gid*16 +: 16], bus.req_b[gid*16 +: 16]}));
        end else begin
            chk("idle_alu", 64'({alu_op, alu_cin, alu_input1, alu_input2}), 64'({ALU_ID, 33'h0}));
        end
        for (int i = 0; i < 3; i++) begin
            if (full[i] && bus.rsp_ready[i]) begin
                e = sbq[i].pop_front();
                chk("rsp_data", 64'({bus.rsp_cout[i], bus.rsp_result[i*16 +: 16]}), 64'(e));
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                sbq[i].push_back(alu_f(bus.req_op[i*4 +: 4], bus.req_a[i*16 +: 16],
                                       bus.req_b[i*16 +: 16], bus.req_cin[i]));
                exp_last = i;
            end
        end
        if ($countones(elig) > 1 && exp_conf != 16'hFFFF) exp_conf = exp_conf + 16'd1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic end_cycle();
        monitor();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  rrdy;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [2:0]  exp_ready;
        logic [1:0]  exp_gid;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{3'b001, 3'b000, ALU_ADD, 16'h7FFF, 16'h0001, 1'b0, 3'b001, 2'd0};
        vecs[1]  = '{3'b000, 3'b001, ALU_ADD, 16'h0000, 16'h0000, 1'b0, 3'b000, 2'd0};
        vecs[2]  = '{3'b111, 3'b111, ALU_ADD, 16'h1000, 16'h0234, 1'b1, 3'b010, 2'd1};
        vecs[3]  = '{3'b111, 3'b111, ALU_SUB, 16'h0010, 16'h0020, 1'b0, 3'b100, 2'd2};
        vecs[4]  = '{3'b111, 3'b111, ALU_AND, 16'hF0F0, 16'h3C3C, 1'b0, 3'b001, 2'd0};
        vecs[5]  = '{3'b111, 3'b111, ALU_OR,  16'h0F00, 16'h00F0, 1'b0, 3'b010, 2'd1};
        vecs[6]  = '{3'b111, 3'b111, ALU_XOR, 16'hAAAA, 16'hFFFF, 1'b0, 3'b100, 2'd2};
        vecs[7]  = '{3'b111, 3'b111, ALU_ADD, 16'hFFFF, 16'hFFFF, 1'b1, 3'b001, 2'd0};
        vecs[8]  = '{3'b111, 3'b101, ALU_ADD, 16'h0001, 16'h0002, 1'b0, 3'b010, 2'd1};
        vecs[9]  = '{3'b111, 3'b101, ALU_SUB, 16'h0300, 16'h0001, 1'b1, 3'b100, 2'd2};
        vecs[10] = '{3'b111, 3'b101, ALU_ID,  16'h5555, 16'h0000, 1'b0, 3'b001, 2'd0};
        vecs[11] = '{3'b111, 3'b101, ALU_ADD, 16'h8000, 16'h8000, 1'b0, 3'b100, 2'd2};
        vecs[12] = '{3'b111, 3'b101, ALU_XOR, 16'h1234, 16'h4321, 1'b0, 3'b001, 2'd0};
        vecs[13] = '{3'b111, 3'b111, ALU_ADD, 16'h0042, 16'h0001, 1'b0, 3'b010, 2'd1};

        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        to_neg();
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'h0);
        chk("rst_rsp_cout", 64'(bus.rsp_cout), 64'h0);
        chk("rst_conflict", 64'(conflict_cnt), 64'h0);
        end_cycle();

        // Table-driven: first op, rotation, a held slot skipped, then released
        for (int v = 0; v < 14; v++) begin
            bus.req_valid = vecs[v].valid;
            bus.rsp_ready = vecs[v].rrdy;
            for (int i = 0; i < 3; i++)
                set_req(i, vecs[v].op, vecs[v].a + 16'(i * 256), vecs[v].b, vecs[v].cin);
            to_neg();
            chk("vec_ready", 64'(bus.req_ready), 64'(vecs[v].exp_ready));
            if (vecs[v].exp_ready != 3'b000) chk("vec_gid", 64'(grant_id), 64'(vecs[v].exp_gid));
            end_cycle();
        end

        // Full slot reloaded when its response leaves in the same cycle as a new grant
        bus.req_valid = 3'b100;
        bus.rsp_ready = 3'b000;
        set_req(2, ALU_ADD, 16'h1234, 16'h0001, 1'b0);
        to_neg();
        end_cycle();
        bus.rsp_ready = 3'b100;
        set_req(2, ALU_SUB, 16'h0005, 16'h0003, 1'b0);
        to_neg();
        chk("reload_ready", 64'(bus.req_ready), 64'h4);
        end_cycle();
        bus.req_valid = 3'b000;
        bus.rsp_ready = 3'b010;
        to_neg();
        chk("reload_valid", 64'(bus.rsp_valid[2]), 64'h1);
        chk("reload_result", 64'(bus.rsp_result[47:32]), 64'h0002);
        end_cycle();
        bus.rsp_ready = 3'b100;
        to_neg();
        end_cycle();

        // Fill every slot, then reset asynchronously mid-cycle
        bus.req_valid = 3'b111;
        bus.rsp_ready = 3'b000;
        repeat (3) begin
            to_neg();
            end_cycle();
        end
        chk("fill_valid", 64'(bus.rsp_valid), 64'h7);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.rsp_valid), 64'h0);
        chk("async_rst_conf", 64'(conflict_cnt), 64'h0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.rsp_ready = 3'b111;
        to_neg();
        chk("first_after_reset", 64'(bus.req_ready), 64'h1);
        end_cycle();

        // Conflict counter saturation
        repeat (65540) begin
            to_neg();
            end_cycle();
        end
        to_neg();
        chk("conf_saturated", 64'(conflict_cnt), 64'hFFFF);
        end_cycle();

        bus.req_valid = 3'b000;
        repeat (2) begin
            to_neg();
            end_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit ALU of the multi-cycle CPU among several requesters: instruction execute, PC increment, and branch-target add. The arbiter grants one requester per cycle using round-robin priority and drives the ALU operands and opcode from the winner. It captures the ALU result in a per-requester response register and holds it until the requester accepts it. It sits between the control unit/datapath requesters and the combinational ALU instance.

## Interface
- N_REQ, 3, number of requesters (index 0 = execute, 1 = PC increment, 2 = branch target)
- DATA_W, 16, operand/result width
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  requester i has an operation to issue
- req_ready  out  N_REQ  requester i granted this cycle (combinational)
- req_op  in  4*N_REQ  ALU opcode per requester (`ALU_*` codes)
- req_a, req_b  in  DATA_W*N_REQ  operands per requester
- req_cin  in  N_REQ  carry-in per requester
- rsp_valid  out  N_REQ  response register i holds a result
- rsp_ready  in  N_REQ  requester i consumes its response
- rsp_result  out  DATA_W*N_REQ  registered result per requester
- rsp_cout  out  N_REQ  registered carry-out per requester
- alu_input1, alu_input2  out  DATA_W  to ALU
- alu_cin  out  1  to ALU
- alu_op  out  4  to ALU
- alu_result  in  DATA_W  from ALU
- alu_cout  in  1  from ALU
- grant_id  out  2  index of current winner (valid when any req_ready)
- conflict_cnt  out  16  saturating count of cycles with >1 eligible requester

## Operation
- Eligibility: requester i is eligible when req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
- Round-robin: last_grant register. Search starts at last_grant+1 modulo N_REQ and takes the first eligible requester. last_grant updates only on a grant.
- Exactly one req_ready bit is high when any requester is eligible; otherwise none.
- The winner's op, a, b, and cin drive the ALU combinationally. With no winner, the ALU sees `ALU_ID` with zero operands and cin=0.
- Each requester's response slot has two states: EMPTY and FULL.
  - EMPTY→FULL on grant.
  - FULL→EMPTY on rsp_ready without a same-cycle grant.
  - FULL stays FULL on rsp_ready together with a grant, and the slot reloads with the new result.
- On grant, rsp_result[i] and rsp_cout[i] capture alu_result and alu_cout. Non-granted slots hold their contents.
- rsp_ready on an EMPTY slot is ignored.
- conflict_cnt increments when two or more requesters are eligible in a cycle and saturates at 16'hFFFF.
- Reset values:
  - rsp_valid = 0, rsp_result = 0, rsp_cout = 0
  - last_grant = N_REQ-1, so requester 0 wins first
  - conflict_cnt = 0
- Reset mid-operation discards pending responses. Requesters must reissue.

## Timing
- Grant and ALU drive happen in cycle T, combinationally from req_valid and slot state.
- The result is registered at the end of T. rsp_valid[i]=1 in T+1.
- Latency is 1 cycle from accepted request to response.
- Throughput: 1 operation/cycle total. A single requester with rsp_ready held high sustains 1 op/cycle.
- The request handshake completes on req_valid & req_ready. Requesters hold op/operands stable while req_valid && !req_ready.
- The response handshake completes on rsp_valid & rsp_ready.
- Simultaneous eligible requesters are served in strict rotation. No requester waits more than N_REQ-1 grants.

## Structure
- `ALU_*` opcode constants come from the shared opcodes.v include. Add `ALU_ARB_NREQ` and the requester index names (`REQ_EXEC`, `REQ_PC`, `REQ_BR`) there.
- One sub-module: rr_picker, a combinational round-robin priority picker. Inputs are the eligible vector and last_grant; outputs are the one-hot grant and the encoded index.
- The ALU stays an external instance. The arbiter contains no arithmetic except the conflict counter.

## Test plan
- Reset, then only req 0 valid with op=`ALU_ADD`, a=16'h7FFF, b=1, cin=0 → req_ready[0] same cycle; next cycle rsp_valid[0]=1, result 16'h8000, cout=0.
- All three valid continuously, rsp_ready all 1 → grants 0,1,2,0,1,2; conflict_cnt increments every cycle.
- Req 1 response held (rsp_ready[1]=0) while req 1 stays valid → req 1 never granted; reqs 0/2 alternate; releasing rsp_ready[1] gives req 1 a grant the same cycle.
- rsp_ready[2] and a new grant to req 2 in the same cycle → rsp_valid[2] stays 1 and the result updates to the new value (`ALU_SUB`, 5 - 3 = 16'h0002).
- Assert reset_n low while slots are FULL → all rsp_valid drop immediately; after release, first grant goes to req 0.
- Force >65535 conflict cycles → conflict_cnt stays at 16'hFFFF.
